hvac_actuator_ctrl: RTL
=======================

// Module: hvac_actuator_ctrl
// PURPOSE
//  Downstream stage of the thermostat controller (temp_top). Consumes its h/c demand bits.
//  Drives the heater, cooler and fan relays with minimum-on time, fan post-purge and minimum-off lockout.
//  Never switches directly between heat and cool. Flags contradictory demand (h and c both high).
// PARAMETERS
//  MIN_ON    default 4   min cycles heat_on/cool_on stays high once asserted (>=1)
//  FAN_POST  default 2   cycles fan stays on after actuator drops (>=1)
//  MIN_OFF   default 3   lockout cycles, all relays off, before next activation (>=1)
//  CNT_W     default 8   timer width; all params must be < 2**CNT_W
// PORTS
//  clk       in   1  clock, rising edge
//  reset     in   1  synchronous, active-high
//  start     in   1  enable; low = no new activation, acts as demand drop
//  h         in   1  heat demand from temp_top
//  c         in   1  cool demand from temp_top
//  heat_on   out  1  heater relay
//  cool_on   out  1  cooler relay
//  fan_on    out  1  fan relay
//  conflict  out  1  h&&c sampled this cycle while in OFF
//  state     out  3  current FSM state (debug)
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state=OFF, timer=0. Reset applies no lockout.
//  - Reset mid-operation has the same effect.
//  - Demand: hd = start&&h&&!c; cd = start&&c&&!h.
//  - OFF: all relays 0.
//    - hd -> HEAT, cd -> COOL. Latency 1 cycle: relay high on the edge after the demand is sampled.
//    - h&&c&&start -> stay OFF, conflict=1 next cycle. conflict=0 in all other cases.
//  - HEAT: heat_on=1, fan_on=1. Timer loaded MIN_ON-1 on entry, decrements to 0.
//    - Leave to PURGE when timer==0 && !hd. So heat_on is high for max(MIN_ON, demand) cycles.
//    - c, or h&&c, during HEAT counts as !hd. Never HEAT->COOL directly.
//  - COOL: mirror of HEAT using cool_on and cd.
//  - PURGE: heat_on=cool_on=0, fan_on=1 for exactly FAN_POST cycles, then LOCKOUT.
//  - LOCKOUT: all relays 0 for exactly MIN_OFF cycles, then OFF. Demand is ignored here.
//    - OFF then activates on the next sampled demand.
//  - Invariant: heat_on&&cool_on never 1. heat_on|cool_on implies fan_on.
//  - Timer saturates at 0 and never wraps.
//  - start dropping mid-HEAT/COOL still honours MIN_ON.
// CONFIGURATION
//  ACT_STATS_EN defined:
//    - Adds outputs heat_starts[15:0] and cool_starts[15:0].
//    - Each increments on entry to HEAT/COOL and saturates at 16'hFFFF.
//    - Cleared by reset.
//  ACT_STATS_EN undefined: these ports still exist, tied to 0, no counter logic.
// STRUCTURE
//  - hvac_pkg: typedef enum logic [2:0] {OFF,HEAT,COOL,PURGE,LOCKOUT} act_state_t; default timing constants.
//  - Sub-module hvac_timer: CNT_W down-counter, load/value inputs, done = (cnt==0), saturating.
//  - Top holds the FSM, the output registers and the optional stats counters.
// TESTING (defaults, 10ns clock)
//  1. Reset, then start=1,h=1 held -> heat_on=fan_on=1 one edge later; stays high while h=1; cool_on=0.
//  2. h pulse 1 cycle -> heat_on high exactly 4 cycles; fan_on 2 more cycles; 3 cycles all 0; state returns OFF.
//  3. c=1 raised during LOCKOUT -> ignored until OFF; cool_on=1 one edge after OFF samples c.
//  4. h=c=1 in OFF -> no relay; conflict=1 each cycle; c drop (h=1) -> HEAT next edge.
//  5. HEAT, h->0, c->1 at cycle 2 -> heat_on to cycle 4, PURGE, LOCKOUT, then COOL; never both relays high.
//  6. Reset asserted mid-HEAT -> all outputs 0 next edge; h=1 right after -> HEAT immediately (no lockout);
//     with ACT_STATS_EN, heat_starts counts 0,1 across this.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared types and default timing for the HVAC actuator controller.
package hvac_pkg;
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    HEAT    = 3'd1,
    COOL    = 3'd2,
    PURGE   = 3'd3,
    LOCKOUT = 3'd4
  } act_state_t;

  localparam int DEF_MIN_ON   = 4;
  localparam int DEF_FAN_POST = 2;
  localparam int DEF_MIN_OFF  = 3;
  localparam int DEF_CNT_W    = 8;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;
endpackage

// File: rtl/hvac_timer.sv
// Saturating down-counter: load takes priority, otherwise counts down and parks at zero.
module hvac_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)             r_cnt <= '0;
    else if (i_load)         r_cnt <= i_value;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/hvac_actuator_ctrl.sv
// Heater/cooler/fan relay sequencer with min-on, fan purge and min-off lockout.
// Optional ACT_STATS_EN adds saturating activation counters.
module hvac_actuator_ctrl
  import hvac_pkg::*;
#(
  parameter int MIN_ON   = DEF_MIN_ON,
  parameter int FAN_POST = DEF_FAN_POST,
  parameter int MIN_OFF  = DEF_MIN_OFF,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        h,
  input  logic        c,
  output logic        heat_on,
  output logic        cool_on,
  output logic        fan_on,
  output logic        conflict,
  output logic [2:0]  state,
  output logic [15:0] heat_starts,
  output logic [15:0] cool_starts
);
  localparam logic [CNT_W-1:0] ON_V  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] FP_V  = CNT_W'(FAN_POST - 1);
  localparam logic [CNT_W-1:0] OFF_V = CNT_W'(MIN_OFF - 1);

  act_state_t       r_state, w_nxt;
  logic             r_heat, r_cool, r_fan, r_conf;
  logic             w_hd, w_cd, w_load, w_done;
  logic [CNT_W-1:0] w_val;

  assign w_hd = start && h && !c;
  assign w_cd = start && c && !h;

  hvac_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_value (w_val),
    .o_done  (w_done)
  );

  // Every transition into a timed state reloads the timer with that state's length-1.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_val  = '0;
    case (r_state)
      OFF: begin
        if (w_hd) begin
          w_nxt = HEAT; w_load = 1'b1; w_val = ON_V;
        end else if (w_cd) begin
          w_nxt = COOL; w_load = 1'b1; w_val = ON_V;
        end
      end
      HEAT: if (w_done && !w_hd) begin
        w_nxt = PURGE; w_load = 1'b1; w_val = FP_V;
      end
      COOL: if (w_done && !w_cd) begin
        w_nxt = PURGE; w_load = 1'b1; w_val = FP_V;
      end
      PURGE: if (w_done) begin
        w_nxt = LOCKOUT; w_load = 1'b1; w_val = OFF_V;
      end
      LOCKOUT: if (w_done) w_nxt = OFF;
      default: w_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OFF;
      r_heat  <= 1'b0;
      r_cool  <= 1'b0;
      r_fan   <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_heat  <= (w_nxt == HEAT);
      r_cool  <= (w_nxt == COOL);
      r_fan   <= (w_nxt inside {HEAT, COOL, PURGE});
      r_conf  <= (r_state == OFF) && start && h && c;
    end
  end

  assign heat_on  = r_heat;
  assign cool_on  = r_cool;
  assign fan_on   = r_fan;
  assign conflict = r_conf;
  assign state    = r_state;

`ifdef ACT_STATS_EN
  logic [15:0] r_hs, r_cs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs <= '0;
      r_cs <= '0;
    end else begin
      if (r_state != HEAT && w_nxt == HEAT && r_hs != STAT_MAX) r_hs <= r_hs + 16'd1;
      if (r_state != COOL && w_nxt == COOL && r_cs != STAT_MAX) r_cs <= r_cs + 16'd1;
    end
  end

  assign heat_starts = r_hs;
  assign cool_starts = r_cs;
`else
  assign heat_starts = '0;
  assign cool_starts = '0;
`endif
endmodule
